// File: rtl/shared_buff_sched_pkg.sv
// Shared types and helpers for the shared-buffer egress scheduler.
// Queue ids, weight normalisation and one-hot encoding live here so the top and its bench agree.
package shared_buff_sched_pkg;

  localparam int WW_DEFAULT = 4;
  localparam int Q_DEFAULT  = 4;
  localparam int Q_MAX      = 32;

  typedef logic [$clog2(Q_DEFAULT)-1:0] qid_t;

  function automatic int qid_width(input int q);
    return (q < 2) ? 1 : $clog2(q);
  endfunction

  // A zero weight still earns one grant per turn so a queue can never be starved by configuration.
  function automatic logic [31:0] eff_w(input logic [31:0] w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

  function automatic logic [Q_MAX-1:0] onehot(input logic [4:0] idx);
    return {{(Q_MAX-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/shared_buff_rr_pick.sv
// Combinational circular first-one finder: returns the first set request at or after i_start,
// wrapping past Q-1 back to 0.
module shared_buff_rr_pick
  import shared_buff_sched_pkg::*;
#(
  parameter int Q  = Q_DEFAULT,
  parameter int QW = qid_width(Q)
) (
  input  logic [Q-1:0]  i_req,
  input  logic [QW-1:0] i_start,
  output logic          o_found,
  output logic [QW-1:0] o_idx
);

  function automatic logic [QW-1:0] wrapIdx(input logic [QW-1:0] s, input int i);
    int c;
    c = int'(s) + i;
    if (c >= Q) c = c - Q;
    return QW'(c);
  endfunction

  // Walk from the farthest candidate back to i_start so the nearest set bit wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = Q - 1; i >= 0; i--) begin
      if (i_req[wrapIdx(i_start, i)]) begin
        o_found = 1'b1;
        o_idx   = wrapIdx(i_start, i);
      end
    end
  end

endmodule

// File: rtl/shared_buff_pop_sched.sv
// Weighted round-robin pop scheduler for the shared buffer's read port, with a one-entry
// output register and valid/ready handshake toward the single downstream sink.
module shared_buff_pop_sched
  import shared_buff_sched_pkg::*;
#(
  parameter int DW = 8,
  parameter int Q  = Q_DEFAULT,
  parameter int WW = WW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 enable_i,
  input  logic [Q*WW-1:0]      weight_i,
  input  logic [Q-1:0]         buf_valid_i,
  input  logic [DW-1:0]        buf_data_i,
  output logic                 buf_pop_o,
  output logic [Q-1:0]         buf_pop_sel_o,
  output logic                 out_valid_o,
  output logic [DW-1:0]        out_data_o,
  output logic [$clog2(Q)-1:0] out_qid_o,
  input  logic                 out_ready_i
);

  localparam int QW = qid_width(Q);
  localparam logic [QW-1:0] LAST_Q = QW'(Q - 1);

  logic [QW-1:0]    r_ptr;
  logic [WW-1:0]    r_credit;
  logic             r_outValid;
  logic [DW-1:0]    r_outData;
  logic [QW-1:0]    r_outQid;

  logic [QW-1:0]    w_start;
  logic             w_pickFound;
  logic [QW-1:0]    w_pickIdx;
  logic             w_stay;
  logic [QW-1:0]    w_sel;
  logic             w_slotFree;
  logic             w_issue;
  logic [WW-1:0]    w_selWeight;
  logic [WW-1:0]    w_reload;
  logic [Q_MAX-1:0] w_sel1hot;

  shared_buff_rr_pick #(
    .Q  (Q),
    .QW (QW)
  ) u_pick (
    .i_req   (buf_valid_i),
    .i_start (w_start),
    .o_found (w_pickFound),
    .o_idx   (w_pickIdx)
  );

  // out_ready_i reaches buf_pop_o through w_slotFree in the same cycle, which is what
  // allows one word per cycle with only a single output register.
  always_comb begin
    w_start     = (r_ptr == LAST_Q) ? '0 : r_ptr + 1'b1;
    w_stay      = buf_valid_i[r_ptr] && (r_credit != '0);
    w_sel       = w_stay ? r_ptr : w_pickIdx;
    w_slotFree  = !r_outValid || out_ready_i;
    w_issue     = !arst && enable_i && w_slotFree && (|buf_valid_i);
    w_selWeight = weight_i[w_sel*WW +: WW];
    w_reload    = WW'(eff_w(32'(w_selWeight)) - 32'd1);
    w_sel1hot   = onehot(5'(w_sel));
    buf_pop_o     = w_issue;
    buf_pop_sel_o = w_issue ? w_sel1hot[Q-1:0] : '0;
  end

  // Weights are only sampled on a switch, so a weight change lands at that queue's next turn.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_ptr      <= LAST_Q;
      r_credit   <= '0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outQid   <= '0;
    end else if (w_issue) begin
      r_outValid <= 1'b1;
      r_outData  <= buf_data_i;
      r_outQid   <= w_sel;
      if (w_stay) begin
        r_credit <= r_credit - 1'b1;
      end else begin
        r_ptr    <= w_sel;
        r_credit <= w_reload;
      end
    end else if (out_ready_i) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid_o = r_outValid;
  assign out_data_o  = r_outData;
  assign out_qid_o   = r_outQid;

`ifndef SYNTHESIS
  a_popValid: assert property (@(posedge clk) disable iff (arst)
    buf_pop_o |-> buf_valid_i[w_sel]);
  a_selOnehot: assert property (@(posedge clk) disable iff (arst)
    $onehot0(buf_pop_sel_o));
  a_noPopBlocked: assert property (@(posedge clk) disable iff (arst)
    !(buf_pop_o && r_outValid && !out_ready_i));
  a_pickFound: assert property (@(posedge clk) disable iff (arst)
    w_issue |-> (w_stay || w_pickFound));
`endif

endmodule

// File: tb/tb_shared_buff_pop_sched.sv
// Bench for shared_buff_pop_sched: a small buffer model feeds head data, and a scoreboard of
// expected (qid, data) pairs is filled at each pop and drained when the output register updates.
module tb_shared_buff_pop_sched;
  import shared_buff_sched_pkg::*;

  logic        clk;
  logic        arst;
  logic        enable_i;
  logic [15:0] weight_i;
  logic [3:0]  buf_valid_i;
  logic [7:0]  buf_data_i;
  logic        buf_pop_o;
  logic [3:0]  buf_pop_sel_o;
  logic        out_valid_o;
  logic [7:0]  out_data_o;
  qid_t        out_qid_o;
  logic        out_ready_i;

  typedef struct {
    logic [1:0] qid;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   expCnt[4] = '{0, 0, 0, 0};
  int   cnt[4]    = '{0, 0, 0, 0};
  int   checks    = 0;
  int   errors    = 0;
  logic       dataOverride = 1'b0;
  logic [7:0] overrideVal  = 8'h00;

  shared_buff_pop_sched #(.DW(8), .Q(4), .WW(4)) dut (
    .clk           (clk),
    .arst          (arst),
    .enable_i      (enable_i),
    .weight_i      (weight_i),
    .buf_valid_i   (buf_valid_i),
    .buf_data_i    (buf_data_i),
    .buf_pop_o     (buf_pop_o),
    .buf_pop_sel_o (buf_pop_sel_o),
    .out_valid_o   (out_valid_o),
    .out_data_o    (out_data_o),
    .out_qid_o     (out_qid_o),
    .out_ready_i   (out_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int q, input int c);
    return 8'((q << 6) | (c & 63));
  endfunction

  // Buffer model: each queue's head word advances every time that queue is popped.
  always @(posedge clk) begin
    for (int q = 0; q < 4; q++)
      if (buf_pop_o && buf_pop_sel_o[q]) cnt[q] <= cnt[q] + 1;
  end

  always_comb begin
    buf_data_i = 8'h00;
    if (dataOverride) buf_data_i = overrideVal;
    else
      for (int q = 0; q < 4; q++)
        if (buf_pop_sel_o[q]) buf_data_i = pat(q, cnt[q]);
  end

  task automatic setWeights(input int w0, input int w1, input int w2, input int w3);
    weight_i = {4'(w3), 4'(w2), 4'(w1), 4'(w0)};
  endtask

  task automatic doReset();
    arst = 1'b1;
    @(posedge clk);
    #1;
    arst = 1'b0;
    sb.delete();
  endtask

  // One scheduling cycle: check the pop strobe/select before the edge, push the expected word,
  // then after the edge pop the scoreboard and compare against the output register.
  task automatic runStep(input string name, input logic expPop, input int expQ);
    logic [3:0] expSel;
    exp_t e;
    @(negedge clk);
    checks++;
    if (buf_pop_o !== expPop) begin
      errors++;
      $display("[TB] FAIL %s pop: got %b expected %b", name, buf_pop_o, expPop);
    end
    expSel = expPop ? 4'(1 << expQ) : 4'b0000;
    checks++;
    if (buf_pop_sel_o !== expSel) begin
      errors++;
      $display("[TB] FAIL %s sel: got %b expected %b", name, buf_pop_sel_o, expSel);
    end
    if (expPop) begin
      e.qid  = 2'(expQ);
      e.data = dataOverride ? overrideVal : pat(expQ, expCnt[expQ]);
      expCnt[expQ]++;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (expPop) begin
      checks++;
      if (out_valid_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s out_valid: got %b expected 1", name, out_valid_o);
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s scoreboard: got empty expected entry", name);
      end else begin
        e = sb.pop_front();
        checks++;
        if (out_qid_o !== e.qid) begin
          errors++;
          $display("[TB] FAIL %s qid: got %0d expected %0d", name, out_qid_o, e.qid);
        end
        checks++;
        if (out_data_o !== e.data) begin
          errors++;
          $display("[TB] FAIL %s data: got %h expected %h", name, out_data_o, e.data);
        end
      end
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    #2;
    checks++;
    if (buf_pop_o !== 1'b0 || buf_pop_sel_o !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_pop: got %b/%b expected 0/0000", buf_pop_o, buf_pop_sel_o);
    end
    checks++;
    if (out_valid_o !== 1'b0 || out_qid_o !== 2'd0 || out_data_o !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_out: got %b/%0d/%h expected 0/0/00", out_valid_o, out_qid_o, out_data_o);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (buf_pop_o !== 1'b0 || out_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold: got %b/%b expected 0/0", buf_pop_o, out_valid_o);
    end
    arst = 1'b0;
    runStep("reset_first", 1'b1, 0);
    // A held word is dropped the moment reset asserts, without waiting for a clock.
    arst = 1'b1;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || buf_pop_o !== 1'b0 || out_data_o !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_discard: got %b/%b/%h expected 0/0/00", out_valid_o, buf_pop_o, out_data_o);
    end
    sb.delete();
    @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  task automatic test_plain_rr();
    int seq[5] = '{0, 1, 2, 3, 0};
    $display("[TB] test_plain_rr");
    setWeights(1, 1, 1, 1);
    buf_valid_i = 4'hF;
    out_ready_i = 1'b1;
    doReset();
    foreach (seq[i]) runStep("plain_rr", 1'b1, seq[i]);
  endtask

  task automatic test_weighted();
    int seq[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    $display("[TB] test_weighted");
    setWeights(3, 1, 1, 1);
    buf_valid_i = 4'b0011;
    out_ready_i = 1'b1;
    doReset();
    foreach (seq[i]) runStep("weighted", 1'b1, seq[i]);
  endtask

  task automatic test_backpressure();
    $display("[TB] test_backpressure");
    setWeights(1, 1, 1, 1);
    buf_valid_i = 4'b0011;
    out_ready_i = 1'b1;
    doReset();
    dataOverride = 1'b1;
    overrideVal  = 8'hA5;
    runStep("bp_load", 1'b1, 0);
    dataOverride = 1'b0;
    out_ready_i  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      runStep("bp_hold", 1'b0, 0);
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== 8'hA5 || out_qid_o !== 2'd0) begin
        errors++;
        $display("[TB] FAIL bp_held: got %b/%h/%0d expected 1/a5/0", out_valid_o, out_data_o, out_qid_o);
      end
    end
    out_ready_i = 1'b1;
    runStep("bp_resume", 1'b1, 1);
  endtask

  task automatic test_early_empty();
    $display("[TB] test_early_empty");
    setWeights(4, 0, 1, 1);
    buf_valid_i = 4'b0011;
    out_ready_i = 1'b1;
    doReset();
    runStep("early_q0", 1'b1, 0);
    runStep("early_q0", 1'b1, 0);
    buf_valid_i = 4'b0010;
    runStep("early_switch", 1'b1, 1);
    buf_valid_i = 4'b0011;
    runStep("w0_one_grant", 1'b1, 0);
    // Lowering q0's weight mid-turn must not cut its current turn short.
    setWeights(1, 0, 1, 1);
    runStep("wchg_q0", 1'b1, 0);
    runStep("wchg_q0", 1'b1, 0);
    runStep("wchg_q0", 1'b1, 0);
    runStep("wchg_q1", 1'b1, 1);
    runStep("wchg_new", 1'b1, 0);
    runStep("wchg_q1b", 1'b1, 1);
  endtask

  task automatic test_enable();
    $display("[TB] test_enable");
    setWeights(3, 1, 1, 1);
    buf_valid_i = 4'hF;
    out_ready_i = 1'b1;
    doReset();
    runStep("en_first", 1'b1, 0);
    enable_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      runStep("en_off", 1'b0, 0);
      checks++;
      if (out_valid_o !== 1'b0 || out_qid_o !== 2'd0) begin
        errors++;
        $display("[TB] FAIL en_drain: got %b/%0d expected 0/0", out_valid_o, out_qid_o);
      end
    end
    enable_i = 1'b1;
    runStep("en_resume", 1'b1, 0);
    runStep("en_resume", 1'b1, 0);
    runStep("en_next", 1'b1, 1);
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    setWeights(1, 1, 2, 1);
    buf_valid_i = 4'b0100;
    out_ready_i = 1'b1;
    doReset();
    for (int i = 0; i < 5; i++) runStep("single_q2", 1'b1, 2);
  endtask

  initial begin
    arst        = 1'b1;
    enable_i    = 1'b1;
    weight_i    = 16'h1111;
    buf_valid_i = 4'hF;
    out_ready_i = 1'b1;
    test_reset();
    test_plain_rr();
    test_weighted();
    test_backpressure();
    test_early_empty();
    test_enable();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
